// File: rtl/forward_selection_datbm_pipe_pkg.sv
// Shared encodings and default widths for the pipelined data/bitmask forward selector.
package forward_selection_datbm_pipe_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_CASC_W = 1;

  typedef enum logic [1:0] {
    CASC_NONE    = 2'b00,
    CASC_LOWER   = 2'b01,
    CASC_UPPER   = 2'b10,
    CASC_ILLEGAL = 2'b11
  } casc_mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_TWO   = 2'b10
  } skid_state_e;

  // The illegal encoding behaves exactly like "no cascade".
  function automatic casc_mode_e eff_mode(input logic [1:0] field);
    return (field == CASC_ILLEGAL) ? CASC_NONE : casc_mode_e'(field);
  endfunction

endpackage

// File: rtl/forward_selection_datbm_pipe_datbm_interleave.sv
// Combinational data/bitmask pair interleave: within each bit pair, data[2k]
// and bitmask[2k+1] trade places when sel_i is set.
module datbm_interleave
  import forward_selection_datbm_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] bitmask_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] bitmask_o
);

  // NOTE: defaults first so every path assigns every bit -- no latch inferred.
  always_comb begin
    data_o    = data_i;
    bitmask_o = bitmask_i;
    if (sel_i) begin
      for (int k = 0; k < DATA_W / 2; k++) begin
        bitmask_o[2*k+1] = data_i[2*k];
        data_o[2*k]      = bitmask_i[2*k+1];
      end
    end
  end

endmodule

// File: rtl/forward_selection_datbm_pipe.sv
// Write-path data/bitmask forward selector: shadowed config, cascade source or
// forward, pair interleave, and a two-entry skid buffer on valid/ready.
module forward_selection_datbm_pipe
  import forward_selection_datbm_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CASC_W = DEF_CASC_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_datbm_sel_i,
  input  logic [1:0]        cfg_cascade_enable_i,
  input  logic              cfg_update_i,
  output logic              cfg_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] bitmask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] bitmask_o,
  input  logic              fwd_valid_i,
  input  logic [CASC_W-1:0] fwd_data_i,
  input  logic [CASC_W-1:0] fwd_bitmask_i,
  output logic              fwd_valid_o,
  output logic [CASC_W-1:0] fwd_data_o,
  output logic [CASC_W-1:0] fwd_bitmask_o
);

  skid_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, head_bm_q, head_bm_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d, tail_bm_q, tail_bm_d;
  logic              sel_q, sel_d;
  logic [1:0]        casc_q, casc_d;
  logic              pend_q, pend_d;
  logic              pend_sel_q, pend_sel_d;
  logic [1:0]        pend_casc_q, pend_casc_d;
  logic              err_q, err_d;

  casc_mode_e        mode;
  logic              src_valid, accept, emit, out_valid;
  logic [DATA_W-1:0] src_data, src_bm, xf_data, xf_bm;

  always_comb begin
    mode      = eff_mode(casc_q);
    src_valid = in_valid_i;
    src_data  = data_i;
    src_bm    = bitmask_i;
    if (mode == CASC_LOWER) begin
      src_valid                = fwd_valid_i;
      src_data                 = '0;
      src_bm                   = '0;
      src_data[CASC_W-1:0]     = fwd_data_i;
      src_bm[CASC_W-1:0]       = fwd_bitmask_i;
    end
  end

  datbm_interleave #(.DATA_W(DATA_W)) u_interleave (
    .sel_i    (sel_q),
    .data_i   (src_data),
    .bitmask_i(src_bm),
    .data_o   (xf_data),
    .bitmask_o(xf_bm)
  );

  assign out_valid = (state_q != SKID_EMPTY);
  assign accept    = src_valid && in_ready_q;
  assign emit      = out_valid && out_ready_i;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_bm_d   = head_bm_q;
    tail_data_d = tail_data_q;
    tail_bm_d   = tail_bm_q;
    case (state_q)
      SKID_EMPTY: if (accept) begin
        head_data_d = xf_data;
        head_bm_d   = xf_bm;
        state_d     = SKID_ONE;
      end
      SKID_ONE: begin
        if (accept && emit) begin
          head_data_d = xf_data;
          head_bm_d   = xf_bm;
        end else if (accept) begin
          tail_data_d = xf_data;
          tail_bm_d   = xf_bm;
          state_d     = SKID_TWO;
        end else if (emit) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: if (emit) begin
        head_data_d = tail_data_q;
        head_bm_d   = tail_bm_q;
        state_d     = SKID_ONE;
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Shadow only moves on an empty pipeline so buffered words keep their transform.
  always_comb begin
    sel_d       = sel_q;
    casc_d      = casc_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    pend_casc_d = pend_casc_q;
    if (cfg_update_i && state_q == SKID_EMPTY && !accept) begin
      sel_d  = cfg_datbm_sel_i;
      casc_d = cfg_cascade_enable_i;
      pend_d = 1'b0;
    end else if (cfg_update_i) begin
      pend_d      = 1'b1;
      pend_sel_d  = cfg_datbm_sel_i;
      pend_casc_d = cfg_cascade_enable_i;
    end else if (pend_q && state_q == SKID_EMPTY) begin
      sel_d  = pend_sel_q;
      casc_d = pend_casc_q;
      pend_d = 1'b0;
    end
    err_d      = err_q || (casc_d == CASC_ILLEGAL);
    in_ready_d = (state_d != SKID_TWO) && !pend_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_bm_q   <= '0;
      tail_data_q <= '0;
      tail_bm_q   <= '0;
      sel_q       <= 1'b0;
      casc_q      <= CASC_NONE;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_casc_q <= CASC_NONE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_bm_q   <= head_bm_d;
      tail_data_q <= tail_data_d;
      tail_bm_q   <= tail_bm_d;
      sel_q       <= sel_d;
      casc_q      <= casc_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      pend_casc_q <= pend_casc_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid;
  assign data_o        = head_data_q;
  assign bitmask_o     = head_bm_q;
  assign cfg_err_o     = err_q;
  assign fwd_valid_o   = (mode == CASC_UPPER) && out_valid;
  assign fwd_data_o    = (mode == CASC_UPPER) ? head_data_q[CASC_W-1:0] : '0;
  assign fwd_bitmask_o = (mode == CASC_UPPER) ? head_bm_q[CASC_W-1:0] : '0;

endmodule

// File: tb/tb_forward_selection_datbm_pipe.sv
// Self-checking bench: directed vector table, hand-written stall/config/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_forward_selection_datbm_pipe;

  localparam int DW = 20;
  localparam int CW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_sel, cfg_update;
  logic [1:0]    cfg_casc;
  logic          cfg_err;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] data_in, bm_in, data_out, bm_out;
  logic          fwd_vi, fwd_vo;
  logic [CW-1:0] fwd_di, fwd_bi, fwd_do, fwd_bo;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  forward_selection_datbm_pipe #(.DATA_W(DW), .CASC_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_datbm_sel_i(cfg_sel), .cfg_cascade_enable_i(cfg_casc),
    .cfg_update_i(cfg_update), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data_in), .bitmask_i(bm_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data_out), .bitmask_o(bm_out),
    .fwd_valid_i(fwd_vi), .fwd_data_i(fwd_di), .fwd_bitmask_i(fwd_bi),
    .fwd_valid_o(fwd_vo), .fwd_data_o(fwd_do), .fwd_bitmask_o(fwd_bo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference transform: odd bits of data stay, even data bits move to odd
  // bitmask bits, odd bitmask bits move to even data bits.
  function automatic logic [2*DW-1:0] model_word(input logic sel, input logic [1:0] casc,
      input logic [DW-1:0] d, input logic [DW-1:0] b, input logic fd, input logic fb);
    logic [DW-1:0] even, odd, sd, sb, nd, nb;
    even = 20'h55555;
    odd  = 20'hAAAAA;
    sd   = (casc == 2'b01) ? DW'(fd) : d;
    sb   = (casc == 2'b01) ? DW'(fb) : b;
    nd   = sel ? ((sd & odd) | ((sb & odd) >> 1)) : sd;
    nb   = sel ? ((sb & even) | ((sd & even) << 1)) : sb;
    return {nd, nb};
  endfunction

  task automatic set_cfg(input logic sel, input logic [1:0] casc);
    cfg_sel    = sel;
    cfg_casc   = casc;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
  endtask

  typedef struct {
    logic          sel;
    logic [1:0]    mode;
    logic [DW-1:0] d, bm;
    logic          fv, fd, fb;
    logic [DW-1:0] ed, ebm;
    logic          efv, efd, efb, eerr;
  } vec_t;

  vec_t vecs[9];

  // Reference-model state for the random phase.
  logic [2*DW-1:0] q[$];
  logic            m_sel, m_pend, p_sel, m_err;
  logic [1:0]      m_casc, p_casc;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] got[$];
    int            next_w;
    logic          acc, em, exp_rdy, src_v;
    logic [1:0]    emode;
    int            sz0;

    vecs[0] = '{1'b1, 2'b00, 20'h00001, 20'h00002, 0, 0, 0, 20'h00001, 20'h00002, 0, 0, 0, 0};
    vecs[1] = '{1'b1, 2'b00, 20'h00001, 20'h00000, 0, 0, 0, 20'h00000, 20'h00002, 0, 0, 0, 0};
    vecs[2] = '{1'b1, 2'b00, 20'h00000, 20'h00002, 0, 0, 0, 20'h00001, 20'h00000, 0, 0, 0, 0};
    vecs[3] = '{1'b0, 2'b00, 20'h00001, 20'h00002, 0, 0, 0, 20'h00001, 20'h00002, 0, 0, 0, 0};
    vecs[4] = '{1'b0, 2'b01, 20'hFFFFF, 20'hFFFFF, 1, 1, 0, 20'h00001, 20'h00000, 0, 0, 0, 0};
    vecs[5] = '{1'b0, 2'b10, 20'h00003, 20'h00002, 0, 0, 0, 20'h00003, 20'h00002, 1, 1, 0, 0};
    vecs[6] = '{1'b1, 2'b10, 20'h12345, 20'h00000, 0, 0, 0, 20'h02200, 20'h2028A, 1, 0, 0, 0};
    vecs[7] = '{1'b0, 2'b00, 20'h00003, 20'h00002, 0, 0, 0, 20'h00003, 20'h00002, 0, 0, 0, 0};
    vecs[8] = '{1'b0, 2'b11, 20'h00003, 20'h00002, 0, 0, 0, 20'h00003, 20'h00002, 0, 0, 0, 1};

    rst = 1'b1; cfg_sel = 0; cfg_casc = 0; cfg_update = 0;
    in_valid = 0; out_ready = 0; data_in = 0; bm_in = 0;
    fwd_vi = 0; fwd_di = 0; fwd_bi = 0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_bitmask", bm_out, 0);
    check("rst_fwd", {fwd_vo, fwd_do, fwd_bo}, 0);
    check("rst_err", cfg_err, 0);

    // Directed table: one word per row, held with out_ready low, then drained.
    foreach (vecs[i]) begin
      set_cfg(vecs[i].sel, vecs[i].mode);
      in_valid = 1'b1; data_in = vecs[i].d; bm_in = vecs[i].bm;
      fwd_vi = vecs[i].fv; fwd_di = vecs[i].fd; fwd_bi = vecs[i].fb;
      step();
      in_valid = 1'b0; fwd_vi = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].ed);
      check($sformatf("vec%0d_bitmask", i), bm_out, vecs[i].ebm);
      check($sformatf("vec%0d_fwd_valid", i), fwd_vo, vecs[i].efv);
      check($sformatf("vec%0d_fwd_data", i), fwd_do, vecs[i].efd);
      check($sformatf("vec%0d_fwd_bitmask", i), fwd_bo, vecs[i].efb);
      check($sformatf("vec%0d_err", i), cfg_err, vecs[i].eerr);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Backpressure: words 1..6 with three stalled cycles at the start.
    set_cfg(1'b0, 2'b00);
    next_w = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (next_w <= 6);
      data_in   = DW'(next_w);
      bm_in     = DW'(next_w);
      if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
      if (cyc == 1 || cyc == 2) begin
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_data", data_out, 1);
      end
      acc = in_valid && in_ready;
      em  = out_valid && out_ready;
      if (em) got.push_back(data_out);
      step();
      if (acc) next_w++;
      if (got.size() == 6) break;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_count", got.size(), 6);
    foreach (got[i]) check($sformatf("bp_order%0d", i), got[i], i + 1);

    // Config while busy: two buffered words keep sel=0, the next uses sel=1.
    in_valid = 1'b1; data_in = 20'h00000; bm_in = 20'h00002;
    step();
    bm_in = 20'h00008;
    step();
    in_valid = 1'b0;
    set_cfg(1'b1, 2'b00);
    check("cfg_busy_ready0", in_ready, 0);
    out_ready = 1'b1;
    check("cfg_busy_wordA", {data_out, bm_out}, {20'h00000, 20'h00002});
    step();
    check("cfg_busy_ready1", in_ready, 0);
    check("cfg_busy_wordB", {data_out, bm_out}, {20'h00000, 20'h00008});
    step();
    out_ready = 1'b0;
    check("cfg_busy_ready2", in_ready, 0);
    for (int w = 0; w < 5 && !in_ready; w++) step();
    check("cfg_busy_ready_back", in_ready, 1);
    in_valid = 1'b1; bm_in = 20'h00002;
    step();
    in_valid = 1'b0;
    check("cfg_busy_wordC", {data_out, bm_out}, {20'h00001, 20'h00000});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset with two words buffered.
    set_cfg(1'b0, 2'b10);
    in_valid = 1'b1; data_in = 20'h00005; bm_in = 20'h00007;
    step(); step();
    in_valid = 1'b0;
    check("rst_pre_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", {data_out, bm_out}, 0);
    check("arst_fwd", {fwd_vo, fwd_do, fwd_bo}, 0);
    check("arst_err", cfg_err, 0);
    step();
    rst = 1'b0;
    step();
    check("arst_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("arst_no_stale", out_valid, 0);
      step();
    end

    // Randomized traffic against the reference model.
    m_sel = 0; m_casc = 0; m_pend = 0; p_sel = 0; p_casc = 0; m_err = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      data_in    = DW'($urandom);
      bm_in      = DW'($urandom);
      fwd_vi     = ($urandom_range(0, 1) != 0);
      fwd_di     = CW'($urandom);
      fwd_bi     = CW'($urandom);
      cfg_update = ($urandom_range(0, 30) == 0);
      cfg_sel    = 1'($urandom);
      cfg_casc   = 2'($urandom);

      exp_rdy = (q.size() < 2) && !m_pend;
      emode   = (m_casc == 2'b11) ? 2'b00 : m_casc;
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) check("rnd_word", {data_out, bm_out}, q[0]);
      if (emode == 2'b10) begin
        check("rnd_fwd_valid", fwd_vo, q.size() > 0);
        if (q.size() > 0) check("rnd_fwd_word", {fwd_do, fwd_bo}, {q[0][DW], q[0][0]});
      end else begin
        check("rnd_fwd_idle", {fwd_vo, fwd_do, fwd_bo}, 0);
      end
      check("rnd_err", cfg_err, m_err);

      src_v = (emode == 2'b01) ? fwd_vi : in_valid;
      acc   = src_v && exp_rdy;
      em    = (q.size() > 0) && out_ready;
      sz0   = q.size();
      step();
      if (em) void'(q.pop_front());
      if (acc) q.push_back(model_word(m_sel, emode, data_in, bm_in, fwd_di, fwd_bi));
      if (cfg_update && sz0 == 0 && !acc) begin
        m_sel = cfg_sel; m_casc = cfg_casc; m_pend = 0;
        if (cfg_casc == 2'b11) m_err = 1;
      end else if (cfg_update) begin
        m_pend = 1; p_sel = cfg_sel; p_casc = cfg_casc;
      end else if (m_pend && sz0 == 0) begin
        m_sel = p_sel; m_casc = p_casc; m_pend = 0;
        if (p_casc == 2'b11) m_err = 1;
      end
    end
    cfg_update = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
